// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM.
// Sequences fetch / decode / execute / memory / writeback for a datapath with
// shared memory and a shared ALU. Moore outputs decode from the state. The
// exceptions are FETCH's memready-dependent strobes and the illegal pulse.
// alucontrol decodes combinationally from aluop and funct.
module mips_mc_controller #(
  parameter int ALUCTL_W     = 3,
  parameter int USE_MEMREADY = 1
) (
  input  logic                clk,
  input  logic                reset,      // asynchronous, active-low
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                memready,
  output logic                pcen,
  output logic                iord,
  output logic                memwrite,
  output logic                irwrite,
  output logic                regdst,
  output logic                memtoreg,
  output logic                regwrite,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsrc,
  output logic [ALUCTL_W-1:0] alucontrol,
  output logic                illegal,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(3'b010);
  localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(3'b110);
  localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(3'b000);
  localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(3'b001);
  localparam logic [ALUCTL_W-1:0] ALU_SLT = ALUCTL_W'(3'b111);

  state_t      state_q, state_d;
  logic        mem_rdy;
  logic        pcwrite;
  logic        branch;
  logic        irwrite_raw;
  logic        regwrite_raw;
  logic        memwrite_raw;
  logic        illegal_raw;
  logic [1:0]  aluop;
  logic        funct_ok;

  // With USE_MEMREADY=0 the memory is assumed to always answer in one cycle.
  assign mem_rdy = (USE_MEMREADY != 0) ? memready : 1'b1;

  // Only the five implemented R-type functions may reach writeback.
  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
      default:                               funct_ok = 1'b0;
    endcase
  end

  // State register; reset returns to FETCH without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic and per-state datapath controls.
  always_comb begin
    state_d      = S_FETCH;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    iord         = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = 2'b00;
    illegal_raw  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb     = 2'b01;
        irwrite_raw = mem_rdy;
        pcwrite     = mem_rdy;
        state_d     = mem_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            // PC already advanced in FETCH, so the instruction is skipped.
            state_d     = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        // The strobe is held for the whole stall, not just the final cycle.
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        state_d      = mem_rdy ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        alusrcb = 2'b00;
        aluop   = 2'b10;
        if (funct_ok) begin
          state_d = S_ALUWB;
        end else begin
          state_d     = S_FETCH;
          illegal_raw = 1'b1;
        end
      end
      S_ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;  // encodings 12-15 recover to FETCH
    endcase
  end

  // ALU function decode; every unlisted combination falls back to add.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      2'b00: alucontrol = ALU_ADD;
      2'b01: alucontrol = ALU_SUB;
      2'b10: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

  // Architectural write enables are suppressed while reset is held low.
  always_comb begin
    pcen     = reset & (pcwrite | (branch & zero));
    irwrite  = reset & irwrite_raw;
    regwrite = reset & regwrite_raw;
    memwrite = reset & memwrite_raw;
    illegal  = reset & illegal_raw;
    state    = state_q;
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: walks each instruction class through
// its state sequence and checks controls against hand-derived values.
module tb_mips_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int wr_cnt = 0;

  mips_mc_controller #(.ALUCTL_W(3), .USE_MEMREADY(1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memready(memready), .pcen(pcen), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  initial begin
    reset = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; memready = 1'b1;
    #12;
    // T1: reset state and gating of enables
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pcen", 32'(pcen), 32'd0);
    chk("rst_irwrite", 32'(irwrite), 32'd0);
    reset = 1'b1; #1;
    chk("fetch_pcen", 32'(pcen), 32'd1);
    chk("fetch_irwrite", 32'(irwrite), 32'd1);
    chk("fetch_alusrcb", 32'(alusrcb), 32'd1);
    op = 6'b101011;
    tick(); chk("sw1_decode", 32'(state), 32'd1);
    chk("decode_alusrcb", 32'(alusrcb), 32'd3);
    tick(); chk("sw1_memadr", 32'(state), 32'd2);
    tick(); chk("sw1_memwr", 32'(state), 32'd5);
    memready = 1'b0; #1;
    chk("sw1_memwrite", 32'(memwrite), 32'd1);
    reset = 1'b0; #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_memwrite", 32'(memwrite), 32'd0);
    reset = 1'b1; #1;
    // FETCH holds while memready is low
    chk("fetch_stall_irwrite", 32'(irwrite), 32'd0);
    tick(); chk("fetch_stall_state", 32'(state), 32'd0);
    memready = 1'b1;

    // T2: lw with no stalls, 5 cycles
    op = 6'b100011; cyc = 0;
    tick(); chk("lw_decode", 32'(state), 32'd1);
    chk("lw_decode_regwrite", 32'(regwrite), 32'd0);
    tick(); chk("lw_memadr", 32'(state), 32'd2);
    chk("lw_memadr_alusrca", 32'(alusrca), 32'd1);
    chk("lw_memadr_alusrcb", 32'(alusrcb), 32'd2);
    tick(); chk("lw_memrd", 32'(state), 32'd3);
    chk("lw_memrd_iord", 32'(iord), 32'd1);
    chk("lw_memrd_regwrite", 32'(regwrite), 32'd0);
    tick(); chk("lw_memwb", 32'(state), 32'd4);
    chk("lw_memwb_regwrite", 32'(regwrite), 32'd1);
    chk("lw_memwb_memtoreg", 32'(memtoreg), 32'd1);
    tick(); chk("lw_done", 32'(state), 32'd0);
    chk("lw_cycles", 32'(cyc), 32'd5);
    // lw with two memready-low cycles in MEMRD, 7 cycles
    cyc = 0;
    tick(); tick(); tick();
    chk("lw2_memrd", 32'(state), 32'd3);
    memready = 1'b0;
    tick(); chk("lw2_stall1", 32'(state), 32'd3);
    tick(); chk("lw2_stall2", 32'(state), 32'd3);
    memready = 1'b1;
    tick(); chk("lw2_memwb", 32'(state), 32'd4);
    tick(); chk("lw2_done", 32'(state), 32'd0);
    chk("lw2_cycles", 32'(cyc), 32'd7);

    // T3: beq taken then not taken
    op = 6'b000100; zero = 1'b1;
    tick(); tick(); chk("beq_branch", 32'(state), 32'd8);
    chk("beq_pcen_taken", 32'(pcen), 32'd1);
    chk("beq_pcsrc", 32'(pcsrc), 32'd1);
    chk("beq_alucontrol", 32'(alucontrol), 32'd6);
    tick(); chk("beq_done", 32'(state), 32'd0);
    zero = 1'b0;
    tick(); tick(); chk("beq2_branch", 32'(state), 32'd8);
    chk("beq_pcen_nottaken", 32'(pcen), 32'd0);
    tick(); chk("beq2_done", 32'(state), 32'd0);

    // T4: R-type slt, plus the other functs seen from EXECUTE
    op = 6'b000000; funct = 6'b101010;
    tick(); tick(); chk("rt_execute", 32'(state), 32'd6);
    chk("rt_slt", 32'(alucontrol), 32'd7);
    chk("rt_alusrca", 32'(alusrca), 32'd1);
    chk("rt_illegal0", 32'(illegal), 32'd0);
    funct = 6'b100100; #1; chk("rt_and", 32'(alucontrol), 32'd0);
    funct = 6'b100101; #1; chk("rt_or", 32'(alucontrol), 32'd1);
    funct = 6'b100010; #1; chk("rt_sub", 32'(alucontrol), 32'd6);
    funct = 6'b100000; #1; chk("rt_add", 32'(alucontrol), 32'd2);
    funct = 6'b101010;
    tick(); chk("rt_aluwb", 32'(state), 32'd7);
    chk("rt_regdst", 32'(regdst), 32'd1);
    chk("rt_regwrite", 32'(regwrite), 32'd1);
    tick(); chk("rt_done", 32'(state), 32'd0);
    funct = 6'b100110;
    tick(); tick(); chk("rtbad_execute", 32'(state), 32'd6);
    chk("rtbad_illegal", 32'(illegal), 32'd1);
    chk("rtbad_alucontrol", 32'(alucontrol), 32'd2);
    chk("rtbad_regwrite", 32'(regwrite), 32'd0);
    tick(); chk("rtbad_state", 32'(state), 32'd0);
    chk("rtbad_illegal_end", 32'(illegal), 32'd0);

    // T5: unsupported opcode
    op = 6'b111111;
    tick(); chk("badop_decode", 32'(state), 32'd1);
    chk("badop_illegal", 32'(illegal), 32'd1);
    chk("badop_enables", 32'({pcen, irwrite, regwrite, memwrite}), 32'd0);
    tick(); chk("badop_state", 32'(state), 32'd0);
    chk("badop_illegal_end", 32'(illegal), 32'd0);

    // T6: sw with memready low for 3 cycles in MEMWR
    op = 6'b101011;
    tick(); tick(); tick(); chk("sw_memwr", 32'(state), 32'd5);
    memready = 1'b0; wr_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (memwrite && iord) wr_cnt++;
      tick();
    end
    memready = 1'b1; #1;
    chk("sw_state_hold", 32'(state), 32'd5);
    if (memwrite && iord) wr_cnt++;
    chk("sw_memwrite_cycles", 32'(wr_cnt), 32'd4);
    tick(); chk("sw_done", 32'(state), 32'd0);
    chk("sw_done_memwrite", 32'(memwrite), 32'd0);

    // addi and j
    op = 6'b001000;
    tick(); tick(); chk("addi_exec", 32'(state), 32'd9);
    chk("addi_alusrcb", 32'(alusrcb), 32'd2);
    tick(); chk("addi_wb", 32'(state), 32'd10);
    chk("addi_regwrite", 32'(regwrite), 32'd1);
    chk("addi_regdst", 32'(regdst), 32'd0);
    tick(); chk("addi_done", 32'(state), 32'd0);
    op = 6'b000010;
    tick(); tick(); chk("j_state", 32'(state), 32'd11);
    chk("j_pcen", 32'(pcen), 32'd1);
    chk("j_pcsrc", 32'(pcsrc), 32'd2);
    tick(); chk("j_done", 32'(state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
